// File: rtl/ysyx_22050243_lsu_pkg.sv
// Shared definitions for the ysyx_22050243 load/store unit:
// funct3 encodings, FSM state type and access-size helpers.
package ysyx_22050243_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // log2 of the access size in bytes
  function automatic logic [1:0] size_log2(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

  function automatic logic [7:0] size_byte_mask(input logic [2:0] funct3);
    case (size_log2(funct3))
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic op_fault(input logic       is_load,
                                    input logic       is_store,
                                    input logic [2:0] funct3,
                                    input logic [2:0] addr_lo);
    logic [2:0] lsb_mask;
    logic       legal_kind;
    case (size_log2(funct3))
      2'd0:    lsb_mask = 3'b000;
      2'd1:    lsb_mask = 3'b001;
      2'd2:    lsb_mask = 3'b011;
      default: lsb_mask = 3'b111;
    endcase
    legal_kind = (is_load && !is_store &&
                  (funct3 inside {F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU})) ||
                 (is_store && !is_load &&
                  (funct3 inside {F3_SB, F3_SH, F3_SW, F3_SD}));
    return !legal_kind || ((addr_lo & lsb_mask) != 3'b000);
  endfunction

endpackage

// File: rtl/ysyx_22050243_lsu_align.sv
// Combinational lane logic: store byte-mask/data shifting and load extract/extend.
module ysyx_22050243_lsu_align
  import ysyx_22050243_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_lane,
  output logic [63:0] load_data
);

  logic [5:0]  shamt;
  logic [63:0] w_shift;
  logic [63:0] r_shift;

  assign shamt   = {addr_lo, 3'b000};
  assign wmask   = size_byte_mask(funct3) << addr_lo;
  assign w_shift = wdata << shamt;
  assign r_shift = rdata >> shamt;

  // bytes outside the enabled lanes are forced to zero
  always_comb begin
    wdata_lane = '0;
    for (int i = 0; i < 8; i++) begin
      if (wmask[i]) wdata_lane[8*i +: 8] = w_shift[8*i +: 8];
    end
  end

  always_comb begin
    case (funct3)
      F3_LB:   load_data = {{56{r_shift[7]}},  r_shift[7:0]};
      F3_LH:   load_data = {{48{r_shift[15]}}, r_shift[15:0]};
      F3_LW:   load_data = {{32{r_shift[31]}}, r_shift[31:0]};
      F3_LD:   load_data = r_shift;
      F3_LBU:  load_data = {56'b0, r_shift[7:0]};
      F3_LHU:  load_data = {48'b0, r_shift[15:0]};
      F3_LWU:  load_data = {32'b0, r_shift[31:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22050243_lsu.sv
// Load/store unit: one aligned 64-bit data-memory access per op, result to write-back.
// Defining LSU_TIMEOUT_EN adds a response timeout of TIMEOUT_CYCLES WAIT cycles.
module ysyx_22050243_lsu
  import ysyx_22050243_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_load,
  input  logic                  ex_store,
  input  logic [2:0]            ex_funct3,
  input  logic [ADDR_WIDTH-1:0] ex_addr,
  input  logic [XLEN-1:0]       ex_wdata,
  input  logic [4:0]            ex_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [7:0]            mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [XLEN-1:0]       wb_rdata,
  output logic [4:0]            wb_rd,
  output logic                  wb_fault
);

  // state | meaning
  // IDLE  | ready for a new op from execute
  // REQ   | memory request presented, waiting for mem_req_ready
  // WAIT  | request accepted, waiting for read data / write ack
  // DONE  | result presented to write-back, waiting for wb_ready

  if (XLEN != 64) begin : g_bad_xlen
    $error("ysyx_22050243_lsu supports XLEN == 64 only");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ysyx_22050243_lsu needs TIMEOUT_CYCLES >= 2");
  end

  lsu_state_e  state;
  logic [2:0]  op_funct3;
  logic [2:0]  op_addr_lo;
  logic        op_load;

  logic [2:0]  a_funct3;
  logic [2:0]  a_addr_lo;
  logic [7:0]  a_wmask;
  logic [63:0] a_wdata_lane;
  logic [63:0] a_load_data;
  logic        accept_fault;

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // One aligner serves both directions: store lanes are needed only at
  // acceptance (IDLE), load extraction only later from the latched op.
  assign a_funct3     = (state == ST_IDLE) ? ex_funct3    : op_funct3;
  assign a_addr_lo    = (state == ST_IDLE) ? ex_addr[2:0] : op_addr_lo;
  assign accept_fault = op_fault(ex_load, ex_store, ex_funct3, ex_addr[2:0]);

  ysyx_22050243_lsu_align u_align (
    .funct3     (a_funct3),
    .addr_lo    (a_addr_lo),
    .wdata      (ex_wdata),
    .rdata      (mem_rdata),
    .wmask      (a_wmask),
    .wdata_lane (a_wdata_lane),
    .load_data  (a_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ex_ready      <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_wen       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      wb_valid      <= 1'b0;
      wb_rdata      <= '0;
      wb_rd         <= '0;
      wb_fault      <= 1'b0;
      op_funct3     <= '0;
      op_addr_lo    <= '0;
      op_load       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (ex_valid && ex_ready) begin
            ex_ready   <= 1'b0;
            op_funct3  <= ex_funct3;
            op_addr_lo <= ex_addr[2:0];
            op_load    <= ex_load;
            wb_rd      <= ex_rd;
            wb_rdata   <= '0;
            if (accept_fault) begin
              state    <= ST_DONE;
              wb_valid <= 1'b1;
              wb_fault <= 1'b1;
            end else begin
              state         <= ST_REQ;
              mem_req_valid <= 1'b1;
              mem_wen       <= ex_store;
              mem_addr      <= {ex_addr[ADDR_WIDTH-1:3], 3'b000};
              mem_wmask     <= a_wmask;
              mem_wdata     <= ex_store ? a_wdata_lane : '0;
            end
          end
        end

        ST_REQ: begin
          if (mem_req_ready) begin
            state         <= ST_WAIT;
            mem_req_valid <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end
        end

        ST_WAIT: begin
          if (mem_rsp_valid) begin
            state    <= ST_DONE;
            wb_valid <= 1'b1;
            wb_fault <= 1'b0;
            wb_rdata <= op_load ? a_load_data : '0;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state    <= ST_DONE;
            wb_valid <= 1'b1;
            wb_fault <= 1'b1;
            wb_rdata <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        ST_DONE: begin
          if (wb_ready) begin
            state    <= ST_IDLE;
            ex_ready <= 1'b1;
            wb_valid <= 1'b0;
            wb_fault <= 1'b0;
            wb_rdata <= '0;
            wb_rd    <= '0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// Self-checking bench for ysyx_22050243_lsu: directed plan items plus randomized ops
// against a byte-level reference model. Timeout scenarios run when LSU_TIMEOUT_EN is defined.
module tb_ysyx_22050243_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        wb_valid, wb_ready;
  logic [63:0] wb_rdata;
  logic [4:0]  wb_rd;
  logic        wb_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22050243_lsu #(.ADDR_WIDTH(64), .XLEN(64), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rdata(wb_rdata), .wb_rd(wb_rd),
    .wb_fault(wb_fault)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_fault(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [63:0] addr);
    int nb = nbytes_of(f3);
    if (ld == st) return 1;
    if (ld && f3 == 3'd7) return 1;
    if (st && f3 > 3'd3) return 1;
    return (int'(addr % 8) % nb) != 0;
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr,
                                           input logic [63:0] rdata);
    int nb = nbytes_of(f3);
    int off = int'(addr % 8);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++)
      if (i < nb) r[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (f3 < 3'd3 && r[8*nb-1])
      for (int i = 0; i < 8; i++)
        if (i >= nb) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [7:0] ref_mask(input logic [2:0] f3, input logic [63:0] addr);
    int nb = nbytes_of(f3);
    int off = int'(addr % 8);
    logic [7:0] m = '0;
    for (int i = 0; i < 8; i++) m[i] = (i >= off) && (i < off + nb);
    return m;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [2:0] f3, input logic [63:0] addr,
                                            input logic [63:0] wdata);
    logic [7:0] m = ref_mask(f3, addr);
    int off = int'(addr % 8);
    logic [63:0] d = '0;
    for (int i = 0; i < 8; i++)
      if (m[i]) d[8*i +: 8] = wdata[8*(i-off) +: 8];
    return d;
  endfunction

  // ---------------- op driver / observer ----------------
  int          o_wb_edge, o_req_cycles, o_wb_cycles;
  bit          o_req_seen, o_wb_seen, o_req_unstable, o_wb_unstable;
  bit          o_ex_ready_early, o_done;
  logic        o_ex_ready_after;
  logic        o_req_wen;
  logic [63:0] o_req_addr, o_req_wdata, o_wb_rdata;
  logic [7:0]  o_req_wmask;
  logic [4:0]  o_wb_rd;
  logic        o_wb_fault;

  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                        input logic [63:0] rdata, input int req_stall, input int wb_stall,
                        input int rsp_cycle);
    int edges = 0, n = 0, wait_cnt = 0;
    bit in_wait = 0, hs_req, hs_wb;
    o_wb_edge = -1; o_req_cycles = 0; o_wb_cycles = 0;
    o_req_seen = 0; o_wb_seen = 0; o_req_unstable = 0; o_wb_unstable = 0;
    o_ex_ready_early = 0; o_done = 0;
    o_req_wen = 'x; o_req_addr = 'x; o_req_wdata = 'x; o_req_wmask = 'x;
    o_wb_rdata = 'x; o_wb_rd = 'x; o_wb_fault = 'x;
    while (ex_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (ex_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL ex_ready_wait got=%b exp=1", ex_ready);
      return;
    end
    ex_valid = 1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    @(posedge clk); #1; edges = 1;
    ex_valid = 0;
    while (!o_done && edges < 100) begin
      if (ex_ready) o_ex_ready_early = 1;
      if (wb_valid) in_wait = 0;
      if (mem_req_valid) begin
        o_req_cycles++;
        if (!o_req_seen) begin
          o_req_seen = 1; o_req_wen = mem_wen; o_req_addr = mem_addr;
          o_req_wdata = mem_wdata; o_req_wmask = mem_wmask;
        end else if ({o_req_wen, o_req_addr, o_req_wdata, o_req_wmask} !==
                     {mem_wen, mem_addr, mem_wdata, mem_wmask}) o_req_unstable = 1;
      end
      if (wb_valid) begin
        o_wb_cycles++;
        if (!o_wb_seen) begin
          o_wb_seen = 1; o_wb_edge = edges;
          o_wb_rdata = wb_rdata; o_wb_rd = wb_rd; o_wb_fault = wb_fault;
        end else if ({o_wb_rdata, o_wb_rd, o_wb_fault} !== {wb_rdata, wb_rd, wb_fault})
          o_wb_unstable = 1;
      end
      mem_req_ready = mem_req_valid && (o_req_cycles > req_stall);
      wb_ready      = wb_valid && (o_wb_cycles > wb_stall);
      mem_rsp_valid = 0;
      mem_rdata     = {$urandom, $urandom};
      if (in_wait) begin
        wait_cnt++;
        if (wait_cnt == rsp_cycle) begin mem_rsp_valid = 1; mem_rdata = rdata; end
      end
      hs_req = mem_req_valid && mem_req_ready;
      hs_wb  = wb_valid && wb_ready;
      @(posedge clk); #1; edges++;
      if (hs_req) in_wait = 1;
      if (hs_wb) o_done = 1;
    end
    mem_req_ready = 0; mem_rsp_valid = 0; wb_ready = 0;
    o_ex_ready_after = ex_ready;
    if (!o_done) begin
      checks++; failures++;
      $display("FAIL op_complete got=incomplete exp=write-back handshake within 100 cycles");
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [208:0] outs;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    outs = {mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
            wb_valid, wb_rdata, wb_rd, wb_fault};
    checks++;
    if (ex_ready !== 1'b1) begin failures++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready); end
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    logic [63:0] word = 64'h1122_3344_8566_7788;
    run_op(1, 0, 3'b000, 64'h8000_0003, 64'h0, 5'd7, word, 0, 0, 1);
    checks++;
    if (o_req_addr !== 64'h8000_0000) begin failures++; $display("FAIL lb_mem_addr got=%h exp=%h", o_req_addr, 64'h8000_0000); end
    checks++;
    if (o_req_wen !== 1'b0) begin failures++; $display("FAIL lb_mem_wen got=%b exp=0", o_req_wen); end
    checks++;
    if (o_wb_rdata !== 64'hFFFF_FFFF_FFFF_FF85) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffffffffffff85", o_wb_rdata); end
    checks++;
    if (o_wb_edge != 3) begin failures++; $display("FAIL lb_latency got=%0d exp=3", o_wb_edge); end
    checks++;
    if (o_wb_rd !== 5'd7 || o_wb_fault !== 1'b0) begin failures++; $display("FAIL lb_rd_fault got=%0d/%b exp=7/0", o_wb_rd, o_wb_fault); end
    run_op(1, 0, 3'b100, 64'h8000_0003, 64'h0, 5'd8, word, 0, 0, 1);
    checks++;
    if (o_wb_rdata !== 64'h85) begin failures++; $display("FAIL lbu_rdata got=%h exp=85", o_wb_rdata); end
    for (int k = 0; k < 24; k++) begin
      logic [2:0]  f3 = 3'($urandom_range(0, 6));
      int          nb = nbytes_of(f3);
      logic [63:0] a  = ({$urandom, $urandom} & ~64'h7) | 64'(($urandom_range(0, 7) / nb) * nb);
      logic [63:0] rdw = {$urandom, $urandom};
      logic [4:0]  rd = 5'($urandom);
      run_op(1, 0, f3, a, {$urandom, $urandom}, rd, rdw, 0, 0, 1);
      checks++;
      if (o_wb_rdata !== ref_load(f3, a, rdw) || o_wb_fault !== 1'b0)
        begin failures++; $display("FAIL rand_load f3=%0d addr=%h got=%h/%b exp=%h/0", f3, a, o_wb_rdata, o_wb_fault, ref_load(f3, a, rdw)); end
      checks++;
      if (o_req_addr !== (a & ~64'h7) || o_wb_rd !== rd)
        begin failures++; $display("FAIL rand_load_addr_rd got=%h/%0d exp=%h/%0d", o_req_addr, o_wb_rd, a & ~64'h7, rd); end
    end
  endtask

  task automatic test_store();
    run_op(0, 1, 3'b001, 64'h8000_0006, 64'h1234_ABCD, 5'd3, 64'h0, 0, 0, 1);
    checks++;
    if (o_req_wen !== 1'b1) begin failures++; $display("FAIL sh_mem_wen got=%b exp=1", o_req_wen); end
    checks++;
    if (o_req_wmask !== 8'hC0) begin failures++; $display("FAIL sh_wmask got=%h exp=c0", o_req_wmask); end
    checks++;
    if (o_req_wdata !== 64'hABCD_0000_0000_0000) begin failures++; $display("FAIL sh_wdata got=%h exp=abcd000000000000", o_req_wdata); end
    checks++;
    if (o_wb_fault !== 1'b0 || o_wb_rdata !== 64'h0) begin failures++; $display("FAIL sh_wb got=%b/%h exp=0/0", o_wb_fault, o_wb_rdata); end
    for (int k = 0; k < 16; k++) begin
      logic [2:0]  f3 = 3'($urandom_range(0, 3));
      int          nb = nbytes_of(f3);
      logic [63:0] a  = ({$urandom, $urandom} & ~64'h7) | 64'(($urandom_range(0, 7) / nb) * nb);
      logic [63:0] wd = {$urandom, $urandom};
      run_op(0, 1, f3, a, wd, 5'd0, 64'h0, 0, 0, 1);
      checks++;
      if (o_req_wmask !== ref_mask(f3, a) || o_req_wdata !== ref_wdata(f3, a, wd))
        begin failures++; $display("FAIL rand_store f3=%0d addr=%h got=%h/%h exp=%h/%h", f3, a, o_req_wmask, o_req_wdata, ref_mask(f3, a), ref_wdata(f3, a, wd)); end
    end
  endtask

  task automatic test_fault();
    run_op(1, 0, 3'b010, 64'h8000_0002, 64'h0, 5'd9, 64'h0, 0, 0, 1);
    checks++;
    if (o_req_seen) begin failures++; $display("FAIL lw_misalign_req got=1 exp=0"); end
    checks++;
    if (o_wb_edge != 1 || o_wb_fault !== 1'b1) begin failures++; $display("FAIL lw_misalign_wb got=%0d/%b exp=1/1", o_wb_edge, o_wb_fault); end
    run_op(1, 1, 3'b011, 64'h8000_0000, 64'h0, 5'd9, 64'h0, 0, 0, 1);
    checks++;
    if (o_req_seen || o_wb_fault !== 1'b1) begin failures++; $display("FAIL both_ld_st got=%b/%b exp=0/1", o_req_seen, o_wb_fault); end
    run_op(0, 0, 3'b000, 64'h8000_0000, 64'h0, 5'd9, 64'h0, 0, 0, 1);
    checks++;
    if (o_req_seen || o_wb_fault !== 1'b1) begin failures++; $display("FAIL neither_ld_st got=%b/%b exp=0/1", o_req_seen, o_wb_fault); end
  endtask

  task automatic test_back_pressure();
    run_op(0, 1, 3'b011, 64'h9000_0008, 64'hDEAD_BEEF_0123_4567, 5'd1, 64'h0, 3, 2, 1);
    checks++;
    if (o_req_cycles != 4 || o_req_unstable) begin failures++; $display("FAIL bp_req got=%0d/%b exp=4/0", o_req_cycles, o_req_unstable); end
    checks++;
    if (o_wb_cycles != 3 || o_wb_unstable) begin failures++; $display("FAIL bp_wb got=%0d/%b exp=3/0", o_wb_cycles, o_wb_unstable); end
    checks++;
    if (o_ex_ready_early || o_ex_ready_after !== 1'b1) begin failures++; $display("FAIL bp_ex_ready got=%b/%b exp=0/1", o_ex_ready_early, o_ex_ready_after); end
  endtask

  task automatic test_random_mix();
    for (int k = 0; k < 40; k++) begin
      logic        ld = 1'($urandom), st;
      logic [2:0]  f3 = 3'($urandom);
      logic [63:0] a = {$urandom, $urandom}, wd = {$urandom, $urandom}, rdw = {$urandom, $urandom};
      logic [4:0]  rd = 5'($urandom);
      int          rs = $urandom_range(0, 3), ws = $urandom_range(0, 3);
      bit          flt;
      st = ($urandom_range(0, 7) == 0) ? ld : !ld;
      if ($urandom_range(0, 1)) a[2:0] = 3'b000;
      flt = ref_fault(ld, st, f3, a);
      run_op(ld, st, f3, a, wd, rd, rdw, rs, ws, 1);
      checks++;
      if (o_wb_fault !== flt || o_req_seen == flt)
        begin failures++; $display("FAIL mix_fault ld=%b st=%b f3=%0d addr=%h got=%b/%b exp=%b", ld, st, f3, a, o_wb_fault, o_req_seen, flt); end
      checks++;
      if (o_wb_edge != (flt ? 1 : 3 + rs) || o_wb_rd !== rd || o_req_unstable || o_wb_unstable || o_ex_ready_early)
        begin failures++; $display("FAIL mix_timing got=%0d/%0d/%b/%b/%b exp=%0d/%0d/0/0/0", o_wb_edge, o_wb_rd, o_req_unstable, o_wb_unstable, o_ex_ready_early, flt ? 1 : 3 + rs, rd); end
      if (!flt) begin
        checks++;
        if (o_wb_rdata !== (ld ? ref_load(f3, a, rdw) : 64'h0) || o_req_wen !== st)
          begin failures++; $display("FAIL mix_data got=%h/%b exp=%h/%b", o_wb_rdata, o_req_wen, ld ? ref_load(f3, a, rdw) : 64'h0, st); end
        if (st) begin
          checks++;
          if (o_req_wmask !== ref_mask(f3, a) || o_req_wdata !== ref_wdata(f3, a, wd))
            begin failures++; $display("FAIL mix_store got=%h/%h exp=%h/%h", o_req_wmask, o_req_wdata, ref_mask(f3, a), ref_wdata(f3, a, wd)); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [208:0] outs;
    ex_valid = 1; ex_load = 1; ex_store = 0; ex_funct3 = 3'b011;
    ex_addr = 64'h8000_0010; ex_rd = 5'd4;
    @(posedge clk); #1;
    ex_valid = 0; mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    #2 rst_n = 0;
    #1;
    outs = {mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
            wb_valid, wb_rdata, wb_rd, wb_fault};
    checks++;
    if (outs !== '0 || ex_ready !== 1'b1) begin failures++; $display("FAIL midreset_outputs got=%h/%b exp=0/1", outs, ex_ready); end
    @(posedge clk); #1;
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      mem_rsp_valid = 1; mem_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
      checks++;
      if (wb_valid !== 1'b0 || mem_req_valid !== 1'b0 || ex_ready !== 1'b1)
        begin failures++; $display("FAIL midreset_late_rsp got=%b/%b/%b exp=0/0/1", wb_valid, mem_req_valid, ex_ready); end
    end
    mem_rsp_valid = 0;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    logic [63:0] rdw = 64'h0123_4567_89AB_CDEF;
    run_op(1, 0, 3'b011, 64'h8000_0020, 64'h0, 5'd5, rdw, 0, 0, 0);
    checks++;
    if (o_wb_fault !== 1'b1 || o_wb_rdata !== 64'h0 || o_wb_edge != 6)
      begin failures++; $display("FAIL timeout_fire got=%b/%h/%0d exp=1/0/6", o_wb_fault, o_wb_rdata, o_wb_edge); end
    run_op(1, 0, 3'b011, 64'h8000_0020, 64'h0, 5'd5, rdw, 0, 0, 3);
    checks++;
    if (o_wb_fault !== 1'b0 || o_wb_rdata !== rdw || o_wb_edge != 5)
      begin failures++; $display("FAIL timeout_rsp3 got=%b/%h/%0d exp=0/%h/5", o_wb_fault, o_wb_rdata, o_wb_edge, rdw); end
    run_op(1, 0, 3'b011, 64'h8000_0020, 64'h0, 5'd5, rdw, 0, 0, 4);
    checks++;
    if (o_wb_fault !== 1'b0 || o_wb_rdata !== rdw || o_wb_edge != 6)
      begin failures++; $display("FAIL timeout_rsp4 got=%b/%h/%0d exp=0/%h/6", o_wb_fault, o_wb_rdata, o_wb_edge, rdw); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got=simulation still running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0; ex_valid = 0; ex_load = 0; ex_store = 0; ex_funct3 = 0;
    ex_addr = 0; ex_wdata = 0; ex_rd = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0; wb_ready = 0;
    test_reset();
    test_load();
    test_store();
    test_fault();
    test_back_pressure();
    test_random_mix();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22050243_lsu.md
Name: ysyx_22050243_lsu

Overview:
- Load/store unit sitting directly upstream of the data memory.
- Takes one decoded memory op from execute and issues one aligned 64-bit access with a byte mask.
- Extracts and sign- or zero-extends load data, then hands the result to write-back.
- Flags misaligned or illegal ops without touching memory.

Parameters:
- ADDR_WIDTH, 64, width of byte address.
- XLEN, 64, data width; must be 64.
- TIMEOUT_CYCLES, 256, response wait limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  op offered.
- ex_ready  out  1  LSU can accept an op.
- ex_load  in  1  op is a load.
- ex_store  in  1  op is a store.
- ex_funct3  in  3  RISC-V funct3 (size/sign).
- ex_addr  in  ADDR_WIDTH  byte address.
- ex_wdata  in  XLEN  store data, right-justified.
- ex_rd  in  5  load destination register.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_wen  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_WIDTH  ex_addr with bits [2:0] cleared.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wmask  out  8  byte enables.
- mem_rsp_valid  in  1  read data or write ack.
- mem_rdata  in  XLEN  read data.
- wb_valid  out  1  result available.
- wb_ready  in  1  write-back consumes the result.
- wb_rdata  out  XLEN  extended load data; 0 for stores.
- wb_rd  out  5  latched ex_rd.
- wb_fault  out  1  misaligned, illegal or timeout.

Behaviour:
- clk is the only clock. rst_n is asynchronous, active-low.
- While rst_n is low:
  - state = IDLE.
  - All outputs are 0 except ex_ready, which is 1 once the FSM is in IDLE.
  - Any in-flight op is dropped.
  - Reset mid-operation requires the memory to be reset too, so no stray response arrives.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - ex_ready = 1.
  - On ex_valid && ex_ready, latch all ex_* fields.
  - If the op faults, go to DONE with wb_fault = 1 and issue no memory request; otherwise go to REQ.
- Fault conditions (any one):
  - ex_load == ex_store.
  - Load with funct3 == 111.
  - Store with funct3[2] == 1.
  - addr[2:0] not a multiple of the access size (1/2/4/8 bytes).
- REQ:
  - mem_req_valid = 1.
  - mem_addr, mem_wen, mem_wdata and mem_wmask are held stable until mem_req_ready.
  - On mem_req_ready, go to WAIT.
- WAIT:
  - Wait for mem_rsp_valid; a response in the same cycle the state is entered counts.
  - On a load, wb_rdata = extend((mem_rdata >> 8*addr[2:0]) truncated to size).
  - LB/LH/LW sign-extend; LBU/LHU/LWU/LD zero-extend (LD needs none).
  - Then go to DONE.
- DONE:
  - wb_valid = 1; wb_* held stable until wb_ready.
  - On wb_ready, go to IDLE.
- Write mask and data:
  - mem_wmask = {1, 3, F, FF}[size] << addr[2:0].
  - mem_wdata = ex_wdata << 8*addr[2:0]; bytes outside the mask are don't-care but driven to 0.
- Latency with zero back-pressure: acceptance edge, then 3 edges later wb_valid = 1. A fault reaches wb_valid 1 edge after acceptance.
- ex_ready = 0 outside IDLE, so there is no overlap of operations.
- mem_rsp_valid outside WAIT is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without mem_rsp_valid, go to DONE with wb_fault = 1 and wb_rdata = 0.
  - A response arriving later is ignored.
- Undefined: no counter; WAIT blocks indefinitely.

Decomposition:
- Package ysyx_22050243_lsu_pkg holds:
  - funct3 constants (LB=000 … LWU=110; SB … SD).
  - The state enum.
  - A size-decode function.
- Sub-module ysyx_22050243_lsu_align is combinational and contains:
  - store lane shift and mask generation;
  - load extract and extend.
- The top level owns the FSM, latches and timeout counter.

Test Plan:
1. Load LB, addr 0x8000_0003, mem_rdata 0x1122_3344_8566_7788 -> mem_addr 0x8000_0000, mem_wen 0, wb_rdata 0xFFFF_FFFF_FFFF_FF85; same op as LBU -> 0x85; wb_valid 3 edges after acceptance.
2. Store SH, addr 0x8000_0006, ex_wdata 0x1234_ABCD -> mem_wen 1, mem_wmask 0xC0, mem_wdata 0xABCD_0000_0000_0000; on ack, wb_fault 0 and wb_rdata 0.
3. Load LW, addr 0x8000_0002 -> mem_req_valid never asserted; wb_valid and wb_fault 1 one edge after acceptance. Also ex_load = ex_store = 1 -> fault.
4. Back-pressure: mem_req_ready low 3 cycles, then wb_ready low 2 cycles -> mem_* stable throughout REQ; wb_* stable throughout DONE; ex_ready 0 until the DONE handshake.
5. Reset: rst_n pulsed low in WAIT, then a late mem_rsp_valid -> immediate return to IDLE, all outputs 0, ex_ready 1, late response ignored.
6. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4: no response -> wb_fault 1 after 4 WAIT cycles; a response on the 3rd cycle completes normally.
